// File: rtl/ama_riscv_mem_arb_if.sv
// Bus bundle between IF/MEM requesters, the unified-memory arbiter and the memory.
// The arbiter takes the slave side; requesters and memory take the master side.
interface ama_riscv_mem_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_kill;
    logic              if_gnt;
    logic              if_rsp_valid;
    logic [DW-1:0]     if_rsp_data;

    logic              dm_req;
    logic              dm_we;
    logic [DW/8-1:0]   dm_wmask;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic              dm_gnt;
    logic              dm_rsp_valid;
    logic [DW-1:0]     dm_rsp_data;

    logic              mem_req;
    logic              mem_we;
    logic [DW/8-1:0]   mem_wmask;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_data;

    logic              err_rsp;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_gnt, if_rsp_valid, if_rsp_data,
        input  dm_req, dm_we, dm_wmask, dm_addr, dm_wdata,
        output dm_gnt, dm_rsp_valid, dm_rsp_data,
        output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        input  mem_ready, mem_rsp_valid, mem_rsp_data,
        output err_rsp
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_gnt, if_rsp_valid, if_rsp_data,
        output dm_req, dm_we, dm_wmask, dm_addr, dm_wdata,
        input  dm_gnt, dm_rsp_valid, dm_rsp_data,
        input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
        output mem_ready, mem_rsp_valid, mem_rsp_data,
        input  err_rsp
    );
endinterface

// File: rtl/ama_riscv_mem_arb.sv
// Shares one memory port between fetch and data requesters, one access in flight.
// Optional macro AMA_RISCV_MEM_ARB_STARVE_EN enables the fetch starvation guard.
module ama_riscv_mem_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    ama_riscv_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_kill_pend;
    logic   r_err_rsp;
    logic   w_starve_hit;
    logic   w_sel_if;
    logic   w_mem_req;
    logic   w_if_gnt;
    logic   w_dm_gnt;
    logic   w_if_rsp;
    logic   w_dm_rsp;
    logic   w_err_set;

    assign w_sel_if = bus.if_req & (~bus.dm_req | w_starve_hit);

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_if_gnt  = 1'b0;
        w_dm_gnt  = 1'b0;
        w_if_rsp  = 1'b0;
        w_dm_rsp  = 1'b0;
        w_err_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_mem_req = bus.if_req | bus.dm_req;
                w_err_set = bus.mem_rsp_valid;
                if (w_mem_req && bus.mem_ready) begin
                    if (w_sel_if) begin
                        w_if_gnt = 1'b1;
                        w_next   = BUSY_IF;
                    end else begin
                        w_dm_gnt = 1'b1;
                        w_next   = BUSY_DM;
                    end
                end
            end
            BUSY_IF: begin
                if (bus.mem_rsp_valid) begin
                    w_if_rsp = ~r_kill_pend & ~bus.if_kill;
                    w_next   = IDLE;
                end
            end
            BUSY_DM: begin
                if (bus.mem_rsp_valid) begin
                    w_dm_rsp = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_kill_pend <= 1'b0;
            r_err_rsp   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_err_rsp <= r_err_rsp | w_err_set;
            // the response itself retires the kill; a kill can never outlive its fetch
            if (r_state == BUSY_IF && bus.mem_rsp_valid)
                r_kill_pend <= 1'b0;
            else if (bus.if_kill && (r_state == BUSY_IF || w_if_gnt))
                r_kill_pend <= 1'b1;
        end
    end

`ifdef AMA_RISCV_MEM_ARB_STARVE_EN
    localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);
    logic [3:0] r_starve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_starve <= 4'd0;
        else if (!bus.if_req || w_if_gnt)
            r_starve <= 4'd0;
        else if (r_starve != LP_MAX)
            r_starve <= r_starve + 4'd1;
    end

    assign w_starve_hit = (r_starve == LP_MAX);
`else
    assign w_starve_hit = 1'b0;
`endif

    // outputs held low while rst is asserted, even though grants are combinational
    logic w_on;
    logic w_drv;
    assign w_on  = ~rst;
    assign w_drv = w_on & w_mem_req;

    assign bus.if_gnt       = w_on & w_if_gnt;
    assign bus.dm_gnt       = w_on & w_dm_gnt;
    assign bus.if_rsp_valid = w_on & w_if_rsp;
    assign bus.dm_rsp_valid = w_on & w_dm_rsp;
    assign bus.if_rsp_data  = w_on ? bus.mem_rsp_data : '0;
    assign bus.dm_rsp_data  = w_on ? bus.mem_rsp_data : '0;
    assign bus.mem_req      = w_drv;
    assign bus.mem_we       = w_drv & ~w_sel_if & bus.dm_we;
    assign bus.mem_wmask    = (w_drv && !w_sel_if) ? bus.dm_wmask : '0;
    assign bus.mem_addr     = !w_drv ? '0 : (w_sel_if ? bus.if_addr : bus.dm_addr);
    assign bus.mem_wdata    = (w_drv && !w_sel_if) ? bus.dm_wdata : '0;
    assign bus.err_rsp      = r_err_rsp;
endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Directed bench for ama_riscv_mem_arb; memory responses are driven by hand.
// Starvation expectations follow AMA_RISCV_MEM_ARB_STARVE_EN.
module tb_ama_riscv_mem_arb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

`ifdef AMA_RISCV_MEM_ARB_STARVE_EN
    localparam int EXP_IF_ARB = 2;
`else
    localparam int EXP_IF_ARB = -1;
`endif

    ama_riscv_mem_arb_if #(.AW(32), .DW(32)) bus ();

    ama_riscv_mem_arb #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        rst               = 1'b1;
        bus.if_req        = 1'b0;
        bus.if_addr       = '0;
        bus.if_kill       = 1'b0;
        bus.dm_req        = 1'b1;
        bus.dm_we         = 1'b0;
        bus.dm_wmask      = '0;
        bus.dm_addr       = 32'h0000_1000;
        bus.dm_wdata      = '0;
        bus.mem_ready     = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_dm_gnt", 32'(bus.dm_gnt), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_err", 32'(bus.err_rsp), 0);

        nx(); rst = 1'b0; bus.dm_req = 1'b0;
        #1 chk("idle_no_req", 32'(bus.mem_req), 0);

        // lone fetch, L = 2
        nx(); bus.if_req = 1'b1; bus.if_addr = 32'h40;
        #1;
        chk("lf_gnt", 32'(bus.if_gnt), 1);
        chk("lf_mem_req", 32'(bus.mem_req), 1);
        chk("lf_addr", bus.mem_addr, 32'h40);
        chk("lf_we", 32'(bus.mem_we), 0);
        nx(); bus.if_req = 1'b0;
        #1;
        chk("lf_busy_req", 32'(bus.mem_req), 0);
        chk("lf_busy_gnt", 32'(bus.if_gnt), 0);
        nx(); bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h13;
        #1;
        chk("lf_rsp_v", 32'(bus.if_rsp_valid), 1);
        chk("lf_rsp_d", bus.if_rsp_data, 32'h13);
        chk("lf_rsp_gnt", 32'(bus.if_gnt), 0);
        chk("lf_rsp_dmv", 32'(bus.dm_rsp_valid), 0);
        nx(); bus.mem_rsp_valid = 1'b0; bus.if_req = 1'b0;
        #1 chk("lf_idle", 32'(bus.if_gnt), 0);

        // contention: dm first, then if
        nx(); bus.if_req = 1'b1; bus.if_addr = 32'h48;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1000;
        #1;
        chk("ct_dm_gnt", 32'(bus.dm_gnt), 1);
        chk("ct_if_gnt", 32'(bus.if_gnt), 0);
        chk("ct_addr", bus.mem_addr, 32'h1000);
        nx(); bus.dm_req = 1'b0;
        #1 chk("ct_busy", 32'(bus.if_gnt), 0);
        nx(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hA5A5_0001;
        #1;
        chk("ct_dm_rsp", 32'(bus.dm_rsp_valid), 1);
        chk("ct_dm_data", bus.dm_rsp_data, 32'hA5A5_0001);
        chk("ct_if_rsp", 32'(bus.if_rsp_valid), 0);
        nx(); bus.mem_rsp_valid = 1'b0;
        #1;
        chk("ct_if_gnt2", 32'(bus.if_gnt), 1);
        chk("ct_if_addr", bus.mem_addr, 32'h48);
        nx(); bus.if_req = 1'b0;
        nx(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0093;
        #1 chk("ct_if_rsp2", 32'(bus.if_rsp_valid), 1);
        nx(); bus.mem_rsp_valid = 1'b0;

        // kill: grant t, kill t+1, response t+3
        nx(); bus.if_req = 1'b1; bus.if_addr = 32'h80;
        #1 chk("kl_gnt", 32'(bus.if_gnt), 1);
        nx(); bus.if_req = 1'b0; bus.if_kill = 1'b1;
        nx(); bus.if_kill = 1'b0;
        nx(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234;
        #1 chk("kl_rsp_sup", 32'(bus.if_rsp_valid), 0);
        nx(); bus.mem_rsp_valid = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_wmask = 4'h3;
        bus.dm_addr = 32'h2000; bus.dm_wdata = 32'h55;
        #1;
        chk("kl_dm_gnt", 32'(bus.dm_gnt), 1);
        chk("kl_dm_we", 32'(bus.mem_we), 1);
        chk("kl_dm_mask", 32'(bus.mem_wmask), 32'h3);
        nx(); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        nx(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0;
        #1 chk("kl_dm_rsp", 32'(bus.dm_rsp_valid), 1);
        nx(); bus.mem_rsp_valid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h84;
        #1 chk("kl_nf_gnt", 32'(bus.if_gnt), 1);
        nx(); bus.if_req = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0033;
        #1 chk("kl_nf_rsp", 32'(bus.if_rsp_valid), 1);
        nx(); bus.mem_rsp_valid = 1'b0;

        // back-pressure on a store
        nx(); bus.mem_ready = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_wmask = 4'hF;
        bus.dm_addr = 32'h3000; bus.dm_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req", 32'(bus.mem_req), 1);
            chk("bp_gnt", 32'(bus.dm_gnt), 0);
            chk("bp_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("bp_addr", bus.mem_addr, 32'h3000);
            nx();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("bp_gnt_rdy", 32'(bus.dm_gnt), 1);
        chk("bp_mask", 32'(bus.mem_wmask), 32'hF);
        nx(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_wmask = '0;
        nx(); bus.mem_rsp_valid = 1'b1;
        #1 chk("bp_rsp", 32'(bus.dm_rsp_valid), 1);
        nx(); bus.mem_rsp_valid = 1'b0;

        // starvation with dm held, L = 1
        nx(); bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h4000;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rsp_valid = 1'b0;
            #1;
            chk("sv_if_gnt", 32'(bus.if_gnt), 32'(i == EXP_IF_ARB));
            chk("sv_dm_gnt", 32'(bus.dm_gnt), 32'(i != EXP_IF_ARB));
            nx(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'(i);
            #1 chk("sv_if_rsp", 32'(bus.if_rsp_valid), 32'(i == EXP_IF_ARB));
            nx();
        end
        bus.mem_rsp_valid = 1'b0; bus.if_req = 1'b0; bus.dm_req = 1'b0;

        // stray response, then reset during BUSY_DM
        nx(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hBAD;
        #1;
        chk("er_if_v", 32'(bus.if_rsp_valid), 0);
        chk("er_dm_v", 32'(bus.dm_rsp_valid), 0);
        nx(); bus.mem_rsp_valid = 1'b0;
        #1 chk("er_sticky", 32'(bus.err_rsp), 1);
        nx(); bus.dm_req = 1'b1; bus.dm_addr = 32'h5000;
        #1 chk("er_dm_gnt", 32'(bus.dm_gnt), 1);
        nx(); rst = 1'b1;
        #1;
        chk("rs_mem_req", 32'(bus.mem_req), 0);
        chk("rs_dm_gnt", 32'(bus.dm_gnt), 0);
        chk("rs_err", 32'(bus.err_rsp), 0);
        chk("rs_rsp_d", bus.dm_rsp_data, 0);
        nx(); rst = 1'b0;
        #1 chk("rs_idle_gnt", 32'(bus.dm_gnt), 1);
        nx(); bus.dm_req = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h77;
        #1;
        chk("rs_rsp_v", 32'(bus.dm_rsp_valid), 1);
        chk("rs_rsp_d2", bus.dm_rsp_data, 32'h77);
        nx(); bus.mem_rsp_valid = 1'b0;
        #1 chk("rs_err_clr", 32'(bus.err_rsp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
